// File: rtl/perf_counter_poller_pkg.sv
// Shared management package for the perf counter poller: perf register IDs,
// sweep slot table, FSM state enum and slot helpers.
// Build option: PERF_POLLER_SGMII_EN adds the SGMII counters (slots 0-3) to
// the sweep; without it the sweep covers slots 4-8 only.
package perf_counter_poller_pkg;

    localparam int         NUM_SLOTS = 9;
    localparam logic [3:0] LAST_SLOT = 4'(NUM_SLOTS - 1);

`ifdef PERF_POLLER_SGMII_EN
    localparam logic [3:0] FIRST_SLOT = 4'd0;
`else
    localparam logic [3:0] FIRST_SLOT = 4'd4;
`endif

    typedef enum logic [15:0] {
        PERF_ID_SGMII_RX_FRAMES = 16'h0000,
        PERF_ID_SGMII_TX_FRAMES = 16'h0001,
        PERF_ID_SGMII_RX_ERRORS = 16'h0002,
        PERF_ID_SGMII_TX_ERRORS = 16'h0003,
        PERF_ID_MAC_RX_BYTES    = 16'h1000,
        PERF_ID_MAC_TX_BYTES    = 16'h1001,
        PERF_ID_DMA_RD_REQS     = 16'h1180,
        PERF_ID_DMA_WR_REQS     = 16'h1181,
        PERF_ID_DMA_STALLS      = 16'h1182
    } perf_reg_id_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLDOFF,
        ST_ADVANCE
    } poller_state_e;

    // Readout address polled for each snapshot slot.
    function automatic logic [15:0] slot_addr(input logic [3:0] slot);
        logic [15:0] addr;
        case (slot)
            4'd0:    addr = PERF_ID_SGMII_RX_FRAMES;
            4'd1:    addr = PERF_ID_SGMII_TX_FRAMES;
            4'd2:    addr = PERF_ID_SGMII_RX_ERRORS;
            4'd3:    addr = PERF_ID_SGMII_TX_ERRORS;
            4'd4:    addr = PERF_ID_MAC_RX_BYTES;
            4'd5:    addr = PERF_ID_MAC_TX_BYTES;
            4'd6:    addr = PERF_ID_DMA_RD_REQS;
            4'd7:    addr = PERF_ID_DMA_WR_REQS;
            4'd8:    addr = PERF_ID_DMA_STALLS;
            default: addr = 16'h0000;
        endcase
        return addr;
    endfunction

    // True for slots the sweep actually fills; everything else reads as zero.
    function automatic logic slot_in_sweep(input logic [3:0] slot);
`ifdef PERF_POLLER_SGMII_EN
        return slot <= LAST_SLOT;
`else
        return (slot >= 4'd4) && (slot <= LAST_SLOT);
`endif
    endfunction

endpackage

// File: rtl/perf_counter_poller_snap_ram.sv
// Snapshot storage: 16x64, one write port, one registered read port.
// Storage itself is never reset so the last sweep survives a controller reset.
// Slots outside the sweep (and 9-15) read as zero.
module PerfSnapshotRam
    import perf_counter_poller_pkg::*;
(
    input  logic        clk_mgmt,
    input  logic        rst_mgmt,
    input  logic        wr_en,
    input  logic [3:0]  wr_idx,
    input  logic [63:0] wr_data,
    input  logic        rd_en,
    input  logic [3:0]  rd_idx,
    output logic        rd_valid,
    output logic [63:0] rd_data
);

    logic [63:0] mem_q [16];
    logic        rd_valid_q;
    logic [63:0] rd_data_q;

    // Write port; a same-cycle read of this slot still sees the old word.
    always_ff @(posedge clk_mgmt) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Registered read port with one cycle of latency.
    always_ff @(posedge clk_mgmt) begin
        if (rst_mgmt) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= 64'h0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= slot_in_sweep(rd_idx) ? mem_q[rd_idx] : 64'h0;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: rtl/perf_counter_poller.sv
// Perf counter poller: on start, reads each perf register in the slot table
// one at a time and stores the result (or all-ones on timeout) in snapshot RAM.
// Build option: PERF_POLLER_SGMII_EN includes SGMII slots 0-3 in the sweep.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start; busy drops the cycle after done
// ST_ISSUE   | rd_en high for this one cycle; timeout timer loaded
// ST_WAIT    | waiting for rd_valid or timer terminal count
// ST_HOLDOFF | lost read: swallow stray rd_valid for HOLDOFF_CYCLES
// ST_ADVANCE | next slot, or done pulse after the last slot
module perf_counter_poller
    import perf_counter_poller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int HOLDOFF_CYCLES = 64
) (
    input  logic        clk_mgmt,
    input  logic        rst_mgmt,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [3:0]  err_count,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    input  logic        rd_valid,
    input  logic [63:0] rd_data,
    input  logic        snap_rd_en,
    input  logic [3:0]  snap_rd_idx,
    output logic        snap_rd_valid,
    output logic [63:0] snap_rd_data
);

    localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] HOLDOFF_LOAD = 16'(HOLDOFF_CYCLES);

    poller_state_e state_q;
    logic [3:0]    idx_q, idx_d;
    logic [3:0]    err_count_q, err_count_d;
    logic [15:0]   timer_q;
    logic [15:0]   rd_addr_q;
    logic          busy_q, done_q, rd_en_q;
    logic          timer_tc;
    logic          snap_wr_en;
    logic [63:0]   snap_wr_data;

    // Terminal count at 1 so WAIT/HOLDOFF last exactly the loaded number of cycles.
    assign timer_tc     = (timer_q <= 16'd1);
    assign idx_d        = idx_q + 4'd1;
    assign err_count_d  = (err_count_q == 4'hF) ? err_count_q : err_count_q + 4'd1;
    // A response on the expiry cycle wins over the timeout.
    assign snap_wr_en   = (state_q == ST_WAIT) && (rd_valid || timer_tc);
    assign snap_wr_data = rd_valid ? rd_data : {64{1'b1}};

    // Sweep FSM with registered strobes and status.
    always_ff @(posedge clk_mgmt) begin
        if (rst_mgmt) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            err_count_q <= 4'd0;
            timer_q     <= 16'd0;
            rd_addr_q   <= 16'h0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    // done_q high means the previous sweep ends this cycle.
                    if (start && !done_q) begin
                        state_q     <= ST_ISSUE;
                        busy_q      <= 1'b1;
                        err_count_q <= 4'd0;
                        idx_q       <= FIRST_SLOT;
                        rd_en_q     <= 1'b1;
                        rd_addr_q   <= slot_addr(FIRST_SLOT);
                    end
                end
                ST_ISSUE: begin
                    timer_q <= TIMEOUT_LOAD;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (rd_valid) begin
                        state_q <= ST_ADVANCE;
                    end else if (timer_tc) begin
                        err_count_q <= err_count_d;
                        timer_q     <= HOLDOFF_LOAD;
                        state_q     <= ST_HOLDOFF;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                ST_HOLDOFF: begin
                    if (timer_tc) begin
                        state_q <= ST_ADVANCE;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                ST_ADVANCE: begin
                    if (idx_q == LAST_SLOT) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        idx_q     <= idx_d;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= slot_addr(idx_d);
                        state_q   <= ST_ISSUE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    PerfSnapshotRam u_snap (
        .clk_mgmt (clk_mgmt),
        .rst_mgmt (rst_mgmt),
        .wr_en    (snap_wr_en),
        .wr_idx   (idx_q),
        .wr_data  (snap_wr_data),
        .rd_en    (snap_rd_en),
        .rd_idx   (snap_rd_idx),
        .rd_valid (snap_rd_valid),
        .rd_data  (snap_rd_data)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_count_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_perf_counter_poller.sv
// Bench for perf_counter_poller: configurable responder, sweep-level model of
// expected addresses / snapshot contents / error count, per-cycle compare.
module tb_perf_counter_poller;

    localparam int T = 8;
    localparam int H = 6;
`ifdef PERF_POLLER_SGMII_EN
    localparam int          FIRST          = 0;
    localparam int          EXP_BUSY_LIT   = 28;
    localparam int          EXP_SILENT_ERR = 9;
    localparam logic [15:0] FIRST_ADDR_LIT = 16'h0000;
    localparam logic [63:0] SNAP2_LIT      = 64'h0000_0000_0000_0003;
`else
    localparam int          FIRST          = 4;
    localparam int          EXP_BUSY_LIT   = 16;
    localparam int          EXP_SILENT_ERR = 5;
    localparam logic [15:0] FIRST_ADDR_LIT = 16'h1000;
    localparam logic [63:0] SNAP2_LIT      = 64'h0;
`endif
    localparam int NSLOT = 9 - FIRST;

    logic        clk_mgmt = 1'b0;
    logic        rst_mgmt = 1'b1;
    logic        start = 1'b0;
    logic        rd_valid = 1'b0;
    logic [63:0] rd_data = 64'h0;
    logic        snap_rd_en = 1'b0;
    logic [3:0]  snap_rd_idx = 4'd0;
    logic        busy, done, rd_en, snap_rd_valid;
    logic [3:0]  err_count;
    logic [15:0] rd_addr;
    logic [63:0] snap_rd_data;

    perf_counter_poller #(.TIMEOUT_CYCLES(T), .HOLDOFF_CYCLES(H)) dut (
        .clk_mgmt      (clk_mgmt),
        .rst_mgmt      (rst_mgmt),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .err_count     (err_count),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .snap_rd_en    (snap_rd_en),
        .snap_rd_idx   (snap_rd_idx),
        .snap_rd_valid (snap_rd_valid),
        .snap_rd_data  (snap_rd_data)
    );

    always #5 clk_mgmt = ~clk_mgmt;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    logic [15:0] addr_tbl [9] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003,
                                  16'h1000, 16'h1001, 16'h1180, 16'h1181, 16'h1182};

    // Responder configuration: latency in cycles, -1 means never answers.
    int          base_lat = 1;
    int          sp_lat = -1;
    logic [15:0] sp_addr = 16'hFFFF;
    bit          all_silent = 0;
    logic [15:0] salt = 16'h0;

    function automatic int lat_of(input logic [15:0] a);
        if (all_silent) return -1;
        if (a == sp_addr) return sp_lat;
        return base_lat;
    endfunction

    function automatic logic [63:0] resp_val(input logic [15:0] a);
        return {salt, 48'(a) + 48'd1};
    endfunction

    task automatic cfg(input int b, input logic [15:0] sa, input int sl, input bit sil, input logic [15:0] s);
        base_lat = b; sp_addr = sa; sp_lat = sl; all_silent = sil; salt = s;
    endtask

    // Model state
    logic [63:0] exp_snap [16];
    int          exp_err = 0;
    int          rd_seen = 0;
    int          done_seen = 0;
    logic [15:0] first_rd_addr = 16'h0;

    // Outcome of a sweep: answered within T cycles stores data, otherwise all-ones and an error.
    task automatic setup_model(input bit commit);
        int l;
        exp_err = 0;
        for (int s = FIRST; s <= 8; s++) begin
            l = lat_of(addr_tbl[s]);
            if (l >= 1 && l <= T) begin
                if (commit) exp_snap[s] = resp_val(addr_tbl[s]);
            end else begin
                if (commit) exp_snap[s] = '1;
                exp_err++;
            end
        end
        if (exp_err > 15) exp_err = 15;
        rd_seen = 0;
        done_seen = 0;
    endtask

    function automatic logic [63:0] snap_view(input logic [3:0] idx);
        if (int'(idx) >= FIRST && int'(idx) <= 8) return exp_snap[idx];
        return 64'h0;
    endfunction

    // Responder: one outstanding read, answered 'lat' cycles after rd_en.
    int          cyc = 0;
    bit          pend = 0;
    int          due = 0;
    int          resp_l;
    logic [63:0] pend_data = 64'h0;

    always @(posedge clk_mgmt) begin
        cyc++;
        #1;
        rd_valid = 1'b0;
        if (pend && cyc == due) begin
            rd_valid = 1'b1;
            rd_data  = pend_data;
            pend     = 0;
        end
    end

    always @(negedge clk_mgmt) begin
        if (rd_en && !rst_mgmt) begin
            resp_l = lat_of(rd_addr);
            if (resp_l >= 1) begin
                pend      = 1;
                due       = cyc + resp_l;
                pend_data = resp_val(rd_addr);
            end
        end
    end

    // Per-cycle compare against the model.
    logic        pv = 1'b0;
    logic [63:0] pdat = 64'h0;
    logic        prev_done = 1'b0;
    logic        prev_rd_en = 1'b0;

    always @(negedge clk_mgmt) begin
        if (rst_mgmt) begin
            pv = 1'b0; prev_done = 1'b0; prev_rd_en = 1'b0;
        end else begin
            chk("snap_rd_valid", snap_rd_valid, pv);
            if (pv) chk("snap_rd_data", snap_rd_data, pdat);
            if (rd_en) begin
                if (rd_seen == 0) first_rd_addr = rd_addr;
                if (rd_seen < NSLOT) chk("rd_addr_order", rd_addr, addr_tbl[FIRST + rd_seen]);
                else chk("rd_en_extra", 64'(rd_seen), 64'(NSLOT - 1));
                chk("rd_en_single_cycle", prev_rd_en, 1'b0);
                chk("busy_with_rd_en", busy, 1'b1);
                rd_seen++;
            end
            if (done) begin
                chk("busy_at_done", busy, 1'b1);
                chk("err_at_done", err_count, 64'(exp_err));
                done_seen++;
            end
            if (prev_done) chk("busy_after_done", busy, 1'b0);
            prev_done  = done;
            prev_rd_en = rd_en;
            pv   = snap_rd_en;
            pdat = snap_view(snap_rd_idx);
        end
    end

    task automatic run_sweep(input int extra_at, input bit start_on_done, output int nbusy);
        bit seen;
        seen = 0;
        nbusy = 0;
        setup_model(1);
        @(posedge clk_mgmt); #1 start = 1'b1;
        @(posedge clk_mgmt); #1 start = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clk_mgmt);
            start = (extra_at > 0 && k == extra_at);
            if (busy) nbusy++;
            if (done) begin
                seen = 1;
                if (start_on_done) start = 1'b1;
            end
        end
        chk("done_within_budget", seen, 1'b1);
        @(negedge clk_mgmt);
        start = 1'b0;
        repeat (6) @(negedge clk_mgmt);
        #1;
        chk("rd_count", 64'(rd_seen), 64'(NSLOT));
        chk("done_count", 64'(done_seen), 64'd1);
        chk("busy_idle", busy, 1'b0);
        chk("err_count_final", err_count, 64'(exp_err));
    endtask

    task automatic read_one(input int idx, output logic [63:0] v);
        @(posedge clk_mgmt); #1 snap_rd_en = 1'b1; snap_rd_idx = 4'(idx);
        @(posedge clk_mgmt); #1 snap_rd_en = 1'b0;
        @(negedge clk_mgmt);
        v = snap_rd_data;
    endtask

    task automatic read_all();
        logic [63:0] v;
        for (int i = 0; i < 16; i++) read_one(i, v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          nb;
        bit          got;
        logic [63:0] v;
        for (int i = 0; i < 16; i++) exp_snap[i] = 64'h0;

        // Reset values
        repeat (3) @(posedge clk_mgmt);
        @(negedge clk_mgmt);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_err_count", err_count, 4'd0);
        chk("rst_rd_addr", rd_addr, 16'h0);
        chk("rst_snap_rd_valid", snap_rd_valid, 1'b0);
        chk("rst_snap_rd_data", snap_rd_data, 64'h0);
        @(posedge clk_mgmt); #1 rst_mgmt = 1'b0;

        // 2-cycle responder, second start mid-sweep ignored
        cfg(2, 16'hFFFF, -1, 0, 16'h0000);
        run_sweep(4, 0, nb);
        chk("first_rd_addr", first_rd_addr, FIRST_ADDR_LIT);
        chk("err_lat2", err_count, 4'd0);
        read_all();
        read_one(4, v); chk("snap4_lit", v, 64'h0000_0000_0000_1001);
        read_one(2, v); chk("snap2_lit", v, SNAP2_LIT);
        read_one(12, v); chk("snap12_zero", v, 64'h0);

        // 1-cycle responder: minimum sweep length; start on the done cycle ignored
        cfg(1, 16'hFFFF, -1, 0, 16'h0001);
        run_sweep(0, 1, nb);
        chk("busy_cycles_min", 64'(nb), 64'(EXP_BUSY_LIT));

        // 0x1181 answers late, inside HOLDOFF
        cfg(1, 16'h1181, 10, 0, 16'h000A);
        run_sweep(0, 0, nb);
        chk("err_one_timeout", err_count, 4'd1);
        read_all();
        read_one(7, v); chk("snap7_timeout", v, 64'hFFFF_FFFF_FFFF_FFFF);
        read_one(8, v); chk("snap8_not_corrupted", v, 64'h000A_0000_0000_1183);

        // Response exactly on the expiry cycle counts
        cfg(T, 16'hFFFF, -1, 0, 16'h000B);
        run_sweep(0, 0, nb);
        chk("err_expiry_edge", err_count, 4'd0);
        read_one(5, v); chk("snap5_expiry_edge", v, 64'h000B_0000_0000_1002);

        // Fully silent responder
        cfg(1, 16'hFFFF, -1, 1, 16'h000D);
        run_sweep(0, 0, nb);
        chk("err_all_silent", err_count, 64'(EXP_SILENT_ERR));
        read_all();

        // One cycle past expiry is a timeout
        cfg(1, 16'h1000, T + 1, 0, 16'h0005);
        run_sweep(0, 0, nb);
        chk("err_one_past", err_count, 4'd1);
        read_one(4, v); chk("snap4_one_past", v, 64'hFFFF_FFFF_FFFF_FFFF);
        read_all();

        // Reset mid-WAIT abandons the sweep; late response ignored
        cfg(5, 16'hFFFF, -1, 0, 16'h000E);
        setup_model(0);
        @(posedge clk_mgmt); #1 start = 1'b1;
        @(posedge clk_mgmt); #1 start = 1'b0;
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk_mgmt);
            if (rd_en) got = 1;
        end
        chk("abandon_rd_en_seen", got, 1'b1);
        @(negedge clk_mgmt);
        @(negedge clk_mgmt);
        @(posedge clk_mgmt); #1 rst_mgmt = 1'b1;
        @(posedge clk_mgmt);
        @(negedge clk_mgmt);
        chk("midrst_rd_en", rd_en, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_err", err_count, 4'd0);
        @(posedge clk_mgmt); #1 rst_mgmt = 1'b0;
        repeat (20) @(negedge clk_mgmt);
        #1;
        chk("abandon_no_done", 64'(done_seen), 64'd0);
        chk("abandon_one_read", 64'(rd_seen), 64'd1);
        chk("abandon_busy", busy, 1'b0);
        read_one(8, v); chk("snap8_kept_after_reset", v, 64'h0005_0000_0000_1183);
        read_all();

        // Clean sweep after reset
        cfg(3, 16'hFFFF, -1, 0, 16'h000C);
        run_sweep(0, 0, nb);
        read_all();
        read_one(6, v); chk("snap6_after_reset", v, 64'h000C_0000_0000_1181);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
